stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_pkg.sv | 14 +
 rtl/stage_timer.sv | 31 +++
 rtl/stage_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared stage encodings for the stage sequencer
package stage_pkg;

    localparam int STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        ST_IF   = 3'd0,
        ST_EXST = 3'd1,
        ST_MEM  = 3'd2,
        ST_SEND = 3'd3,
        ST_HALT = 3'd4
    } stage_e;

endpackage

// File: rtl/stage_timer.sv
// rtl/stage_timer.sv - saturating wait counter with clear and expire
module stage_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] SAT  = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt < SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the wait cycles already spent, so the LIMIT-th cycle expires
    assign o_expire = i_en && (r_cnt >= LAST);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - IF/EXST/MEM/SEND/HALT control sequencer
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int IF_CYCLES    = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int SEND_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_inst,
    input  logic                mem_force,
    input  logic                send_inst,
    input  logic [2:0]          send_ch,
    input  logic [NUM_CH-1:0]   UART_TE,
    input  logic                mem_ack,
    input  logic                halt,
    input  logic                err_clr,
    output logic                EXSTtoMEM_Wen,
    output logic                IR_Wen,
    output logic                PC_Wen,
    output logic                PSR_Wen,
    output logic                RF_Wen,
    output logic                ST_Wen,
    output logic [NUM_CH-1:0]   UART_load,
    output logic                mem_req,
    output logic [STAGE_W-1:0]  stage,
    output logic                mem_err,
    output logic                send_err
);

    localparam int FW = $clog2(IF_CYCLES + 1);
    localparam logic [FW-1:0] FETCH_LAST = FW'(IF_CYCLES - 1);

    stage_e      r_state;
    stage_e      w_next;
    logic [FW-1:0] r_fetch;
    logic [2:0]  r_ch_q;
    logic        r_mem_err;
    logic        r_send_err;

    logic w_fetch_last, w_halt_now, w_ch_ok, w_te_sel;
    logic w_mem_to, w_send_to, w_mem_err_set, w_send_err_set;

    assign w_fetch_last = (r_fetch == FETCH_LAST);
    assign w_halt_now   = (r_fetch == '0) && halt;
    assign w_ch_ok      = ({29'd0, send_ch} < NUM_CH);

    always_comb begin
        w_te_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_q == 3'(i)) w_te_sel = UART_TE[i];
        end
    end

    stage_timer #(.LIMIT(MEM_TIMEOUT)) u_mem_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (r_state != ST_MEM),
        .i_en     (r_state == ST_MEM),
        .o_expire (w_mem_to)
    );

    stage_timer #(.LIMIT(SEND_TIMEOUT)) u_send_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (r_state != ST_SEND),
        .i_en     (r_state == ST_SEND),
        .o_expire (w_send_to)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IF;
        case (r_state)
            ST_IF:   w_next = w_halt_now ? ST_HALT : (w_fetch_last ? ST_EXST : ST_IF);
            ST_EXST: begin
                if (mem_inst)                  w_next = ST_MEM;
                else if (send_inst && w_ch_ok) w_next = ST_SEND;
                else                           w_next = ST_IF;
            end
            ST_MEM: begin
                if (mem_ack)       w_next = mem_force ? ST_EXST : ST_IF;
                else if (w_mem_to) w_next = ST_IF;
                else               w_next = ST_MEM;
            end
            ST_SEND: w_next = (w_te_sel || w_send_to) ? ST_IF : ST_SEND;
            ST_HALT: w_next = halt ? ST_HALT : ST_IF;
            default: w_next = ST_IF;
        endcase
    end

    always_comb begin
        EXSTtoMEM_Wen  = 1'b0;
        IR_Wen         = 1'b0;
        PC_Wen         = 1'b0;
        PSR_Wen        = 1'b0;
        RF_Wen         = 1'b0;
        ST_Wen         = 1'b0;
        UART_load      = '0;
        mem_req        = 1'b0;
        w_mem_err_set  = 1'b0;
        w_send_err_set = 1'b0;
        case (r_state)
            ST_IF:   IR_Wen = w_fetch_last && !w_halt_now;
            ST_EXST: begin
                if (mem_inst) begin
                    EXSTtoMEM_Wen = 1'b1;
                end else if (send_inst) begin
                    if (w_ch_ok) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (send_ch == 3'(i)) UART_load[i] = 1'b1;
                        end
                    end else begin
                        w_send_err_set = 1'b1;
                        PC_Wen         = 1'b1;
                    end
                end else begin
                    PC_Wen  = 1'b1;
                    PSR_Wen = 1'b1;
                    RF_Wen  = 1'b1;
                    ST_Wen  = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    RF_Wen = 1'b1;
                    ST_Wen = 1'b1;
                    PC_Wen = !mem_force;
                end else if (w_mem_to) begin
                    w_mem_err_set = 1'b1;
                    PC_Wen        = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_te_sel) begin
                    PC_Wen = 1'b1;
                end else if (w_send_to) begin
                    w_send_err_set = 1'b1;
                    PC_Wen         = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch    <= '0;
            r_ch_q     <= '0;
            r_mem_err  <= 1'b0;
            r_send_err <= 1'b0;
        end else begin
            if ((r_state == ST_IF) && !w_halt_now && !w_fetch_last) r_fetch <= r_fetch + 1'b1;
            else                                                   r_fetch <= '0;
            if ((r_state == ST_EXST) && !mem_inst && send_inst && w_ch_ok) r_ch_q <= send_ch;
            // a set in the same cycle as err_clr wins
            if (w_mem_err_set)  r_mem_err <= 1'b1;
            else if (err_clr)   r_mem_err <= 1'b0;
            if (w_send_err_set) r_send_err <= 1'b1;
            else if (err_clr)   r_send_err <= 1'b0;
        end
    end

    assign stage    = r_state;
    assign mem_err  = r_mem_err;
    assign send_err = r_send_err;

endmodule
